fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the control unit. Holds the program counter, issues word fetches to instruction memory over a request/acknowledge handshake, and presents one instruction (with its PC and decoded `opcode`/`funct` fields) to the decode/control stage through a valid/ready handshake. Accepts PC redirects from branch, jump and `jr` resolution, and squashes wrong-path fetches.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 35 +++
 rtl/pc_reg.sv | 24 ++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcode/funct constants, the fetch FSM
// state encoding and the default reset PC.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FUNCT_JR = 6'd8;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_SQUASH = 2'd2,
    ST_VALID  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch unit, instruction memory and the decode stage.
// Handshakes: imemReq holds (address stable) until the one-cycle imemAck; an
// instruction transfers on any cycle where instrValid and instrReady are both high.
interface fetch_unit_if;
  import mips_pkg::*;

  logic         imemReq;
  logic [31:0]  imemAddr;
  logic         imemAck;
  logic [31:0]  imemData;
  logic         instrValid;
  logic         instrReady;
  logic [31:0]  instr;
  logic [31:0]  instrPc;
  logic [31:0]  pcPlus4;
  logic [5:0]   opcode;
  logic [5:0]   funct;
  logic         redirect;
  logic [31:0]  redirectPc;
  logic [31:0]  fetchCount;
  fetch_state_e state;

  modport master (
    output imemReq, imemAddr, instrValid, instr, instrPc, pcPlus4,
           opcode, funct, fetchCount, state,
    input  imemAck, imemData, instrReady, redirect, redirectPc
  );

  modport slave (
    input  imemReq, imemAddr, instrValid, instr, instrPc, pcPlus4,
           opcode, funct, fetchCount, state,
    output imemAck, imemData, instrReady, redirect, redirectPc
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter: word-aligned load on redirect, otherwise optional +4 step.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        load,
  input  logic [31:0] load_pc,
  output logic [31:0] pc
);

  // Load beats increment; low two bits are always cleared on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc & 32'hFFFF_FFFC;
    end else if (inc) begin
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word fetches, holds one fetched instruction
// for the decode stage and squashes wrong-path fetches on redirect.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc;
  logic [31:0]  instr_q, instr_pc_q, pend_pc_q, fetch_count_q;
  logic         pc_inc, pc_load, capture, transfer, pend_load;
  logic [31:0]  pc_load_val;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (pc_inc),
    .load    (pc_load),
    .load_pc (pc_load_val),
    .pc      (pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = bus.redirectPc;
    capture     = 1'b0;
    transfer    = 1'b0;
    pend_load   = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.imemAck) begin
          if (bus.redirect) begin
            pc_load = 1'b1;
          end else begin
            capture = 1'b1;
            pc_inc  = 1'b1;
            state_d = ST_VALID;
          end
        end else if (bus.redirect) begin
          // Request is already on the bus; keep the address and remember the target.
          pend_load = 1'b1;
          state_d   = ST_SQUASH;
        end
      end
      ST_SQUASH: begin
        if (bus.imemAck) begin
          pc_load = 1'b1;
          if (!bus.redirect) pc_load_val = pend_pc_q;
          state_d = ST_FETCH;
        end else if (bus.redirect) begin
          pend_load = 1'b1;
        end
      end
      ST_VALID: begin
        if (bus.redirect) begin
          pc_load = 1'b1;
          state_d = ST_FETCH;
        end else if (bus.instrReady) begin
          transfer = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      instr_q       <= 32'h0;
      instr_pc_q    <= RESET_PC;
      pend_pc_q     <= 32'h0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        instr_q    <= bus.imemData;
        instr_pc_q <= pc;
      end
      if (pend_load) pend_pc_q <= bus.redirectPc;
      if (transfer)  fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign bus.imemReq    = (state_q == ST_FETCH) || (state_q == ST_SQUASH);
  assign bus.imemAddr   = pc;
  assign bus.instrValid = (state_q == ST_VALID);
  assign bus.instr      = instr_q;
  assign bus.instrPc    = instr_pc_q;
  assign bus.pcPlus4    = instr_pc_q + 32'd4;
  assign bus.opcode     = instr_q[31:26];
  assign bus.funct      = instr_q[5:0];
  assign bus.fetchCount = fetch_count_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-configurable instruction memory, a
// transaction-level reference model, a per-cycle compare and directed scenarios.
module tb_fetch_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h0001_0003) ^ 32'h3C01_0000;
  endfunction

  // Memory responder: acks after lat extra cycles of a held request.
  int   lat = 0;
  int   cnt = 0;
  logic ack_normal = 1'b0;
  logic force_ack;

  always @(negedge clk) begin
    if (bus.imemReq) begin
      if (cnt == lat) begin
        ack_normal <= 1'b1;
        cnt        <= 0;
      end else begin
        ack_normal <= 1'b0;
        cnt        <= cnt + 1;
      end
    end else begin
      ack_normal <= 1'b0;
      cnt        <= 0;
    end
  end

  assign bus.imemAck  = ack_normal | force_ack;
  assign bus.imemData = mem_word(bus.imemAddr);

  // Reference model: one held instruction slot, one outstanding fetch, and a
  // pending redirect target that is applied once the in-flight fetch returns.
  logic        m_idle, m_valid, m_squash;
  logic [31:0] m_pc, m_target, m_instr, m_ipc, m_count;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle   <= 1'b1;
      m_valid  <= 1'b0;
      m_squash <= 1'b0;
      m_pc     <= 32'h0;
      m_target <= 32'h0;
      m_instr  <= 32'h0;
      m_ipc    <= 32'h0;
      m_count  <= 32'h0;
    end else if (m_idle) begin
      m_idle <= 1'b0;
    end else if (m_valid) begin
      if (bus.redirect) begin
        m_valid <= 1'b0;
        m_pc    <= bus.redirectPc & ~32'h3;
      end else if (bus.instrReady) begin
        m_valid <= 1'b0;
        m_count <= m_count + 32'd1;
      end
    end else if (m_squash) begin
      if (bus.imemAck) begin
        m_squash <= 1'b0;
        m_pc     <= (bus.redirect ? bus.redirectPc : m_target) & ~32'h3;
      end else if (bus.redirect) begin
        m_target <= bus.redirectPc;
      end
    end else begin
      if (bus.imemAck && !bus.redirect) begin
        m_instr <= mem_word(m_pc);
        m_ipc   <= m_pc;
        m_pc    <= m_pc + 32'd4;
        m_valid <= 1'b1;
      end else if (bus.imemAck) begin
        m_pc <= bus.redirectPc & ~32'h3;
      end else if (bus.redirect) begin
        m_squash <= 1'b1;
        m_target <= bus.redirectPc;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_req", 32'(bus.imemReq), 32'(!m_idle && !m_valid));
      check("cmp_valid", 32'(bus.instrValid), 32'(m_valid));
      check("cmp_count", bus.fetchCount, m_count);
      if (!m_idle && !m_valid) check("cmp_addr", bus.imemAddr, m_pc);
      if (m_valid) begin
        check("cmp_instr", bus.instr, m_instr);
        check("cmp_ipc", bus.instrPc, m_ipc);
        check("cmp_pc4", bus.pcPlus4, m_ipc + 32'd4);
        check("cmp_opcode", 32'(bus.opcode), 32'(m_instr[31:26]));
        check("cmp_funct", 32'(bus.funct), 32'(m_instr[5:0]));
      end
    end
  end

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus.instrValid && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (!bus.instrValid) begin
      failures++;
      $display("FAIL wait_valid actual=timeout expected=instrValid within %0d cycles", budget);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    force_ack      = 1'b0;
    bus.instrReady = 1'b0;
    bus.redirect   = 1'b0;
    bus.redirectPc = 32'h0;
    step();
    step();
    check("rst_req", 32'(bus.imemReq), 32'd0);
    check("rst_valid", 32'(bus.instrValid), 32'd0);
    check("rst_state", 32'(bus.state), 32'(ST_IDLE));

    // Zero-wait memory from reset release.
    rst_n = 1'b1;
    step();
    check("t1_req", 32'(bus.imemReq), 32'd1);
    check("t1_novalid", 32'(bus.instrValid), 32'd0);
    check("t1_addr", bus.imemAddr, 32'h0);
    step();
    check("t1_valid", 32'(bus.instrValid), 32'd1);
    check("t1_instr", bus.instr, 32'h2008_0005);
    check("t1_opcode", 32'(bus.opcode), 32'(OP_ADDI));
    check("t1_funct", 32'(bus.funct), 32'd5);
    check("t1_ipc", bus.instrPc, 32'h0);
    check("t1_pc4", bus.pcPlus4, 32'h4);

    // Downstream stall for five cycles.
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_instr", bus.instr, 32'h2008_0005);
      check("t2_hold_ipc", bus.instrPc, 32'h0);
      check("t2_hold_count", bus.fetchCount, 32'd0);
      check("t2_hold_req", 32'(bus.imemReq), 32'd0);
    end
    bus.instrReady = 1'b1;
    step();
    bus.instrReady = 1'b0;
    check("t2_count", bus.fetchCount, 32'd1);
    check("t2_next_addr", bus.imemAddr, 32'h4);
    step();
    check("t2_ipc4", bus.instrPc, 32'h4);

    // 3-cycle memory, redirect one cycle after the request.
    lat = 2;
    bus.instrReady = 1'b1;
    step();
    bus.instrReady = 1'b0;
    check("t3_addr", bus.imemAddr, 32'h8);
    step();
    bus.redirect   = 1'b1;
    bus.redirectPc = 32'h40;
    step();
    bus.redirect = 1'b0;
    check("t3_addr_held", bus.imemAddr, 32'h8);
    check("t3_req_held", 32'(bus.imemReq), 32'd1);
    step();
    check("t3_new_addr", bus.imemAddr, 32'h40);
    check("t3_no_valid", 32'(bus.instrValid), 32'd0);
    wait_valid(10);
    check("t3_ipc", bus.instrPc, 32'h40);
    check("t3_instr", bus.instr, mem_word(32'h40));
    check("t3_count", bus.fetchCount, 32'd2);

    // Redirect and ready in the same VALID cycle.
    lat = 0;
    bus.redirect   = 1'b1;
    bus.redirectPc = 32'h100;
    bus.instrReady = 1'b1;
    step();
    bus.redirect   = 1'b0;
    bus.instrReady = 1'b0;
    check("t4_valid_low", 32'(bus.instrValid), 32'd0);
    check("t4_count", bus.fetchCount, 32'd2);
    check("t4_addr", bus.imemAddr, 32'h100);
    step();
    check("t4_ipc", bus.instrPc, 32'h100);

    // Unaligned redirect near the top of memory and PC wrap.
    bus.redirect   = 1'b1;
    bus.redirectPc = 32'hFFFF_FFFF;
    step();
    bus.redirect = 1'b0;
    check("t5_addr", bus.imemAddr, 32'hFFFF_FFFC);
    step();
    check("t5_ipc", bus.instrPc, 32'hFFFF_FFFC);
    check("t5_pc4", bus.pcPlus4, 32'h0);
    lat = 5;
    bus.instrReady = 1'b1;
    step();
    bus.instrReady = 1'b0;
    check("t5_wrap_addr", bus.imemAddr, 32'h0);
    check("t5_count", bus.fetchCount, 32'd3);

    // Reset while waiting for the memory; late ack lands in IDLE.
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("t6_req", 32'(bus.imemReq), 32'd0);
    check("t6_valid", 32'(bus.instrValid), 32'd0);
    check("t6_count", bus.fetchCount, 32'd0);
    check("t6_instr", bus.instr, 32'h0);
    check("t6_ipc", bus.instrPc, 32'h0);
    check("t6_addr", bus.imemAddr, 32'h0);
    check("t6_state", 32'(bus.state), 32'(ST_IDLE));
    step();
    rst_n     = 1'b1;
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    check("t6_late_valid", 32'(bus.instrValid), 32'd0);
    check("t6_late_req", 32'(bus.imemReq), 32'd1);
    step();
    check("t6_still_no_valid", 32'(bus.instrValid), 32'd0);
    wait_valid(20);
    check("t6_ipc", bus.instrPc, 32'h0);
    check("t6_refetch", bus.instr, 32'h2008_0005);
    bus.instrReady = 1'b1;
    step();
    bus.instrReady = 1'b0;
    check("t6_count_after", bus.fetchCount, 32'd1);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
